id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//   ID/EX pipeline register and operand-select stage directly upstream of the ALU.
//   - Accepts one decoded instruction per cycle over a valid/ready handshake and registers it.
//   - Resolves rs1/rs2 data hazards against the MEM and WB stages.
//   - Drives the ALU operand a, operand b and the 4-bit alu_op.
//   - Passes rd, write-enable and store data downstream.
// PARAMETERS
//   XLEN        32   datapath width; alu_a, alu_b, pc, imm and result widths
//   RESET_PC    0    value loaded into out_pc on reset
// PORTS
//   clk           in   1     rising-edge clock
//   rst           in   1     synchronous, active-high reset
//   in_valid      in   1     decoded instruction presented
//   in_ready      out  1     stage can accept this cycle
//   in_pc         in   XLEN  instruction PC
//   in_rs1        in   5     source register 1 index
//   in_rs2        in   5     source register 2 index
//   in_rs1_val    in   XLEN  regfile read data for rs1
//   in_rs2_val    in   XLEN  regfile read data for rs2
//   in_imm        in   XLEN  sign-extended immediate
//   in_alu_op     in   4     ALU op; [3] = sub/arith, [2:0] = function
//   in_a_sel      in   1     1: operand a = pc, 0: rs1
//   in_b_sel      in   1     1: operand b = imm, 0: rs2
//   in_rd         in   5     destination index
//   in_wen        in   1     instruction writes rd
//   flush         in   1     kill held and incoming instruction (branch redirect)
//   mem_fwd_wen   in   1     MEM stage writes mem_fwd_rd
//   mem_fwd_rd    in   5     MEM destination index
//   mem_fwd_val   in   XLEN  MEM result
//   wb_fwd_wen    in   1     WB stage writes wb_fwd_rd
//   wb_fwd_rd     in   5     WB destination index
//   wb_fwd_val    in   XLEN  WB result
//   out_valid     out  1     alu_* and out_* hold a live instruction
//   out_ready     in   1     downstream consumes this cycle
//   alu_a         out  XLEN  ALU operand a
//   alu_b         out  XLEN  ALU operand b
//   alu_op        out  4     ALU op (registered in_alu_op)
//   out_pc        out  XLEN  registered PC
//   out_rd        out  5     registered rd
//   out_wen       out  1     registered wen, gated by out_valid
//   out_store     out  XLEN  hazard-resolved rs2 value (store data)
// BEHAVIOUR
//   - Reset: out_valid=0, out_pc=RESET_PC; all other registers 0, so alu_op=0 and out_wen=0.
//   - Single register stage, 1-cycle latency, full throughput.
//   - in_ready = (~out_valid | out_ready) & ~stall.
//   - Transfer (in_valid & in_ready): all in_* fields load next edge; out_valid<=1.
//   - Downstream takes the instruction with no new transfer: out_valid<=0.
//   - Stalled (out_valid & ~out_ready): all registers hold; alu_a/alu_b may still change as forwarding sources move.
//   - flush has priority over everything but rst:
//     - out_valid<=0 next edge;
//     - any same-cycle incoming instruction is dropped;
//     - in_ready is not forced low.
//   - Forward select for held source s (combinational):
//     - use mem_fwd_val if mem_fwd_wen & mem_fwd_rd==s & s!=0;
//     - else wb_fwd_val if wb_fwd_wen & wb_fwd_rd==s & s!=0;
//     - else the registered regfile value.
//   - Source index 0 always reads 0, regardless of any forwarding match.
//   - Operand muxes: alu_a = a_sel ? out_pc : rs1_res; alu_b = b_sel ? imm : rs2_res; out_store = rs2_res.
//   - out_wen = wen_q & out_valid.
// CONFIGURATION
//   FWD_EN defined:
//     - forward muxes above active; stall=0.
//   FWD_EN undefined:
//     - no forward muxes; registered regfile values are used directly.
//     - stall=1 while in_valid and any nonzero in_rs1/in_rs2 (read by the instruction) matches:
//       (a) out_rd with out_wen;
//       (b) mem_fwd_rd with mem_fwd_wen;
//       (c) wb_fwd_rd with wb_fwd_wen.
//     - A match against index 0 never stalls.
// TESTING
//   - Reset: hold rst 2 cycles -> out_valid=0, alu_op=0, out_pc=RESET_PC, in_ready=1.
//   - Throughput: 4 back-to-back ADDI (imm 1..4, b_sel=1), out_ready=1 -> one out_valid/cycle, alu_b=1,2,3,4 in order.
//   - Backpressure: out_ready=0 for 3 cycles with an instruction held -> in_ready=0, outputs stable, no instruction lost or duplicated.
//   - Forward priority [FWD_EN]: held rs1=5; mem 5/0xAA and wb 5/0xBB both valid -> alu_a=0xAA.
//   - Forward [FWD_EN]: drop the mem match from the previous case -> alu_a=0xBB.
//   - x0 guard [FWD_EN]: rs1=0 with mem_fwd_rd=0 -> alu_a=0.
//   - Flush: flush together with in_valid & in_ready -> out_valid=0 next cycle; the next accepted instruction issues normally.
//   - Interlock [no FWD_EN]: incoming rs2=7 while mem_fwd_rd=7 & mem_fwd_wen -> in_ready=0 until the match clears, then accepted.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: handshake, forwarding and ALU-side bus of the ID/EX stage.
interface id_ex_stage_if #(parameter int XLEN = 32);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [4:0]      in_rs1;
    logic [4:0]      in_rs2;
    logic [XLEN-1:0] in_rs1_val;
    logic [XLEN-1:0] in_rs2_val;
    logic [XLEN-1:0] in_imm;
    logic [3:0]      in_alu_op;
    logic            in_a_sel;
    logic            in_b_sel;
    logic [4:0]      in_rd;
    logic            in_wen;
    logic            flush;
    logic            mem_fwd_wen;
    logic [4:0]      mem_fwd_rd;
    logic [XLEN-1:0] mem_fwd_val;
    logic            wb_fwd_wen;
    logic [4:0]      wb_fwd_rd;
    logic [XLEN-1:0] wb_fwd_val;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [3:0]      alu_op;
    logic [XLEN-1:0] out_pc;
    logic [4:0]      out_rd;
    logic            out_wen;
    logic [XLEN-1:0] out_store;

    modport master (
        output in_valid, in_pc, in_rs1, in_rs2, in_rs1_val, in_rs2_val, in_imm,
               in_alu_op, in_a_sel, in_b_sel, in_rd, in_wen, flush,
               mem_fwd_wen, mem_fwd_rd, mem_fwd_val, wb_fwd_wen, wb_fwd_rd, wb_fwd_val,
               out_ready,
        input  in_ready, out_valid, alu_a, alu_b, alu_op, out_pc, out_rd, out_wen, out_store
    );

    modport slave (
        input  in_valid, in_pc, in_rs1, in_rs2, in_rs1_val, in_rs2_val, in_imm,
               in_alu_op, in_a_sel, in_b_sel, in_rd, in_wen, flush,
               mem_fwd_wen, mem_fwd_rd, mem_fwd_val, wb_fwd_wen, wb_fwd_rd, wb_fwd_val,
               out_ready,
        output in_ready, out_valid, alu_a, alu_b, alu_op, out_pc, out_rd, out_wen, out_store
    );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register and ALU operand select.
// FWD_EN defined: MEM/WB forwarding muxes; undefined: hazard interlock stalls instead.
module id_ex_stage #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input logic         clk,
    input logic         rst,
    id_ex_stage_if.slave bus
);
    logic            valid_q, a_sel_q, b_sel_q, wen_q, stall, xfer;
    logic [XLEN-1:0] pc_q, rs1_val_q, rs2_val_q, imm_q, rs1_res, rs2_res;
    logic [3:0]      alu_op_q;
    logic [4:0]      rd_q;

`ifdef FWD_EN
    logic [4:0] rs1_q, rs2_q;

    assign stall = 1'b0;

    // MEM is younger than WB, so it wins when both target the same source
    always_comb begin
        rs1_res = rs1_q == 5'd0 ? '0 :
                  (bus.mem_fwd_wen && bus.mem_fwd_rd == rs1_q) ? bus.mem_fwd_val :
                  (bus.wb_fwd_wen && bus.wb_fwd_rd == rs1_q) ? bus.wb_fwd_val : rs1_val_q;
        rs2_res = rs2_q == 5'd0 ? '0 :
                  (bus.mem_fwd_wen && bus.mem_fwd_rd == rs2_q) ? bus.mem_fwd_val :
                  (bus.wb_fwd_wen && bus.wb_fwd_rd == rs2_q) ? bus.wb_fwd_val : rs2_val_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rs1_q <= '0;
            rs2_q <= '0;
        end else if (xfer && !bus.flush) begin
            rs1_q <= bus.in_rs1;
            rs2_q <= bus.in_rs2;
        end
    end
`else
    function automatic logic dep(input logic [4:0] s, input logic [4:0] a, input logic [4:0] b,
                                 input logic [4:0] c, input logic [2:0] en);
        return s != 5'd0 && ((en[0] && a == s) || (en[1] && b == s) || (en[2] && c == s));
    endfunction

    logic [2:0] pend;

    assign pend    = {bus.wb_fwd_wen, bus.mem_fwd_wen, wen_q & valid_q};
    assign stall   = bus.in_valid &&
                     (dep(bus.in_rs1, rd_q, bus.mem_fwd_rd, bus.wb_fwd_rd, pend) ||
                      dep(bus.in_rs2, rd_q, bus.mem_fwd_rd, bus.wb_fwd_rd, pend));
    assign rs1_res = rs1_val_q;
    assign rs2_res = rs2_val_q;
`endif

    assign bus.in_ready = (~valid_q | bus.out_ready) & ~stall;
    assign xfer         = bus.in_valid & bus.in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            pc_q      <= RESET_PC;
            rs1_val_q <= '0;
            rs2_val_q <= '0;
            imm_q     <= '0;
            alu_op_q  <= '0;
            a_sel_q   <= 1'b0;
            b_sel_q   <= 1'b0;
            rd_q      <= '0;
            wen_q     <= 1'b0;
        end else begin
            valid_q <= bus.flush ? 1'b0 : xfer ? 1'b1 : bus.out_ready ? 1'b0 : valid_q;
            if (xfer && !bus.flush) begin
                pc_q      <= bus.in_pc;
                rs1_val_q <= bus.in_rs1_val;
                rs2_val_q <= bus.in_rs2_val;
                imm_q     <= bus.in_imm;
                alu_op_q  <= bus.in_alu_op;
                a_sel_q   <= bus.in_a_sel;
                b_sel_q   <= bus.in_b_sel;
                rd_q      <= bus.in_rd;
                wen_q     <= bus.in_wen;
            end
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.alu_a     = a_sel_q ? pc_q : rs1_res;
    assign bus.alu_b     = b_sel_q ? imm_q : rs2_res;
    assign bus.alu_op    = alu_op_q;
    assign bus.out_pc    = pc_q;
    assign bus.out_rd    = rd_q;
    assign bus.out_wen   = wen_q & valid_q;
    assign bus.out_store = rs2_res;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed self-checking bench for id_ex_stage (FWD_EN cases only when defined).
module tb_id_ex_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    id_ex_stage_if #(.XLEN(32)) bus ();

    id_ex_stage #(.XLEN(32), .RESET_PC(32'h100)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] imm,
                         input logic [3:0] op, input logic a_sel, input logic b_sel,
                         input logic [4:0] rd, input logic wen);
        bus.in_pc = pc;
        bus.in_rs1 = rs1;
        bus.in_rs2 = rs2;
        bus.in_rs1_val = v1;
        bus.in_rs2_val = v2;
        bus.in_imm = imm;
        bus.in_alu_op = op;
        bus.in_a_sel = a_sel;
        bus.in_b_sel = b_sel;
        bus.in_rd = rd;
        bus.in_wen = wen;
    endtask

    initial begin
        bus.in_valid = 0; bus.flush = 0; bus.out_ready = 0;
        bus.mem_fwd_wen = 0; bus.mem_fwd_rd = 0; bus.mem_fwd_val = 0;
        bus.wb_fwd_wen = 0; bus.wb_fwd_rd = 0; bus.wb_fwd_val = 0;
        instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        rst = 0;
        #1;
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_alu_op", bus.alu_op, 0);
        chk("rst_pc", bus.out_pc, 32'h100);
        chk("rst_ready", bus.in_ready, 1);
        chk("rst_wen", bus.out_wen, 0);

        // throughput: four back-to-back ADDI
        bus.out_ready = 1;
        instr(32'h1004, 1, 0, 32'h10, 0, 1, 4'h0, 0, 1, 5'd11, 1);
        bus.in_valid = 1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("tp_valid", bus.out_valid, 1);
            chk("tp_alu_b", bus.alu_b, k);
            chk("tp_pc", bus.out_pc, 32'h1000 + 4 * k);
            chk("tp_ready", bus.in_ready, 1);
            if (k < 4) instr(32'h1000 + 4 * (k + 1), 1, 0, 32'h10, 0, k + 1, 4'h0, 0, 1, 5'(10 + k + 1), 1);
            else bus.in_valid = 0;
        end
        chk("tp_wen", bus.out_wen, 1);
        chk("tp_rd", bus.out_rd, 14);
        tick();
        chk("tp_drain", bus.out_valid, 0);
        chk("tp_drain_wen", bus.out_wen, 0);

        // backpressure: A held 3 cycles while B waits
        bus.out_ready = 0;
        instr(32'h2000, 2, 0, 0, 0, 32'h55, 4'h8, 0, 1, 5'd3, 1);
        bus.in_valid = 1;
        tick();
        chk("bp_valid", bus.out_valid, 1);
        chk("bp_op", bus.alu_op, 4'h8);
        instr(32'h2004, 4, 0, 0, 0, 32'h66, 4'h1, 0, 1, 5'd8, 1);
        #1;
        chk("bp_ready", bus.in_ready, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_hold_valid", bus.out_valid, 1);
            chk("bp_hold_pc", bus.out_pc, 32'h2000);
            chk("bp_hold_b", bus.alu_b, 32'h55);
            chk("bp_hold_ready", bus.in_ready, 0);
        end
        bus.out_ready = 1;
        #1;
        chk("bp_release", bus.in_ready, 1);
        tick();
        chk("bp_next_pc", bus.out_pc, 32'h2004);
        chk("bp_next_b", bus.alu_b, 32'h66);
        chk("bp_next_op", bus.alu_op, 4'h1);
        bus.in_valid = 0;
        tick();
        chk("bp_drain", bus.out_valid, 0);

        // flush kills held C and incoming D; E issues normally
        instr(32'h3000, 0, 0, 0, 0, 32'h77, 4'h0, 0, 1, 5'd0, 0);
        bus.in_valid = 1;
        tick();
        chk("fl_c_valid", bus.out_valid, 1);
        instr(32'h3004, 0, 0, 0, 0, 32'h99, 4'h0, 0, 1, 5'd0, 0);
        bus.flush = 1;
        #1;
        chk("fl_ready", bus.in_ready, 1);
        tick();
        chk("fl_killed", bus.out_valid, 0);
        bus.flush = 0;
        instr(32'h3008, 0, 0, 0, 0, 32'h88, 4'h0, 0, 1, 5'd0, 0);
        tick();
        chk("fl_e_valid", bus.out_valid, 1);
        chk("fl_e_pc", bus.out_pc, 32'h3008);
        chk("fl_e_b", bus.alu_b, 32'h88);
        bus.in_valid = 0;
        tick();

`ifdef FWD_EN
        bus.out_ready = 0;
        instr(32'h4000, 5, 6, 32'h11, 32'h22, 0, 4'h0, 0, 0, 5'd9, 1);
        bus.in_valid = 1;
        tick();
        bus.in_valid = 0;
        bus.mem_fwd_wen = 1; bus.mem_fwd_rd = 5; bus.mem_fwd_val = 32'hAA;
        bus.wb_fwd_wen = 1; bus.wb_fwd_rd = 5; bus.wb_fwd_val = 32'hBB;
        #1;
        chk("fw_prio", bus.alu_a, 32'hAA);
        chk("fw_b_reg", bus.alu_b, 32'h22);
        bus.mem_fwd_wen = 0;
        #1;
        chk("fw_wb", bus.alu_a, 32'hBB);
        bus.wb_fwd_rd = 6;
        #1;
        chk("fw_rs1_reg", bus.alu_a, 32'h11);
        chk("fw_store", bus.out_store, 32'hBB);
        bus.wb_fwd_wen = 0;
        bus.out_ready = 1;
        instr(32'h4004, 0, 0, 32'h33, 32'h44, 0, 4'h0, 0, 0, 5'd9, 1);
        bus.in_valid = 1;
        tick();
        bus.in_valid = 0;
        bus.out_ready = 0;
        bus.mem_fwd_wen = 1; bus.mem_fwd_rd = 0; bus.mem_fwd_val = 32'hCC;
        #1;
        chk("fw_x0_a", bus.alu_a, 0);
        chk("fw_x0_store", bus.out_store, 0);
        bus.mem_fwd_wen = 0;
        bus.out_ready = 1;
        tick();
`else
        // interlock against MEM, then against the held instruction, x0 exempt
        bus.out_ready = 1;
        bus.mem_fwd_wen = 1; bus.mem_fwd_rd = 7;
        instr(32'h5000, 1, 7, 0, 0, 0, 4'h0, 0, 0, 5'd9, 1);
        bus.in_valid = 1;
        #1;
        chk("il_stall", bus.in_ready, 0);
        tick();
        chk("il_none", bus.out_valid, 0);
        chk("il_stall2", bus.in_ready, 0);
        tick();
        chk("il_none2", bus.out_valid, 0);
        bus.mem_fwd_wen = 0;
        #1;
        chk("il_clear", bus.in_ready, 1);
        tick();
        chk("il_acc_valid", bus.out_valid, 1);
        chk("il_acc_pc", bus.out_pc, 32'h5000);
        instr(32'h5004, 9, 0, 0, 0, 0, 4'h0, 0, 0, 5'd2, 1);
        #1;
        chk("il_out_rd", bus.in_ready, 0);
        bus.wb_fwd_wen = 1; bus.wb_fwd_rd = 0;
        instr(32'h5008, 0, 0, 0, 0, 0, 4'h0, 0, 0, 5'd2, 1);
        #1;
        chk("il_x0", bus.in_ready, 1);
        bus.wb_fwd_wen = 0;
        bus.in_valid = 0;
        tick();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
